data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Multi-cycle access sequencer between the pipeline's load/store stage and the L1/L2/L3/main-memory data hierarchy. It accepts one request at a time over a valid/ready handshake and holds the request on the hierarchy ports. It samples the per-level hit flags once, then waits a level-dependent latency before committing a write or capturing read data. It also drives a stall to the pipeline for the whole access.

## Interface
Parameters:
- L1_LAT, 1: cycles charged for an L1 hit (legal range 1..255)
- L2_LAT, 4: cycles charged for an L2 hit (legal range 1..255)
- L3_LAT, 10: cycles charged for an L3 hit (legal range 1..255)
- MEM_LAT, 50: cycles charged for a full miss to main memory (legal range 1..255)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  pipeline request valid
- req_ready_o  out  1  controller can accept a request
- addr_i  in  32  request address
- wr_en_i  in  1  1 = write, 0 = read
- wr_data_i  in  32  write data
- byte_en_i  in  4  byte enables
- mem_addr_o  out  32  latched address to hierarchy
- mem_wr_en_o  out  1  one-cycle write commit to hierarchy
- mem_wr_data_o  out  32  latched write data
- mem_byte_en_o  out  4  latched byte enables
- l1_hit_i / l2_hit_i / l3_hit_i  in  1 each  hit flags from hierarchy for mem_addr_o
- mem_rd_data_i  in  32  read data from hierarchy (already hit-muxed)
- stall_o  out  1  pipeline stall
- rsp_valid_o  out  1  one-cycle completion pulse
- rd_data_o  out  32  captured read data
- perf_l1_o / perf_l2_o / perf_l3_o / perf_mem_o  out  32 each  access counters (see Configuration)

## Operation
- FSM states: IDLE, LOOKUP, WAIT, RESP.
- **IDLE:**
  - req_ready_o = 1.
  - On req_valid_i, latch addr/wr_en/wr_data/byte_en into internal registers and go to LOOKUP.
- **LOOKUP:** sample hit flags once and select the latency with priority L1 > L2 > L3 > main memory.
  - Multiple simultaneous hits resolve by this priority.
  - Load the 8-bit counter with LAT-1, then go to WAIT.
- **WAIT:** decrement the counter each cycle. When the counter reaches 0, take the following actions, then go to RESP:
  - Write request: pulse mem_wr_en_o for exactly this one cycle.
  - Read request: capture mem_rd_data_i into rd_data_o.
- **RESP:** rsp_valid_o = 1 for one cycle, then go to IDLE.
- **Hierarchy outputs:**
  - mem_addr_o, mem_wr_data_o and mem_byte_en_o come from the latched registers.
  - They are stable from LOOKUP through RESP.
  - They hold their last value in IDLE.
- **Input changes mid-access:**
  - Hit flags are ignored outside LOOKUP.
  - Input request fields are ignored outside the IDLE accept cycle.
- Writes use the same hit-selected latency as reads.
- A write with byte_en = 0000 is still sequenced: mem_wr_en_o pulses with mem_byte_en_o = 0000.
- rd_data_o changes only on read capture. Writes leave it unchanged.
- **stall_o** = (state ∈ {LOOKUP, WAIT}) or (state = IDLE and req_valid_i). This is combinational in IDLE so the accepting cycle stalls.
- req_valid_i while not IDLE is not accepted. The requester must hold the request until req_ready_o = 1.

## Timing
- **Reset values:**
  - FSM = IDLE, req_ready_o = 1 after reset.
  - stall_o, rsp_valid_o and mem_wr_en_o = 0.
  - rd_data_o, mem_addr_o, mem_wr_data_o, mem_byte_en_o, counter and perf counters = 0.
- **Per-access timing** (accept at cycle T, latency LAT):
  - LOOKUP at T+1.
  - WAIT from T+2 to T+1+LAT.
  - Write commit or read capture at T+1+LAT.
  - rsp_valid_o at T+2+LAT.
  - Next accept no earlier than T+3+LAT.
- stall_o is high from T through T+1+LAT, i.e. LAT+2 cycles.
- **Reset mid-operation:** return to IDLE next edge. A pending write is never committed and no rsp_valid_o is issued.
- Reset has priority over all transitions, including an accept in the same cycle.

## Configuration
- **DATA_MEM_CTRL_PERF_EN defined:**
  - Four 32-bit counters increment in LOOKUP according to the selected level (L1, L2, L3 or mem).
  - Counters saturate at 0xFFFF_FFFF and clear only on rst.
- **Not defined:** counter logic is absent and all perf_*_o ports are tied to 0. The port list is identical in both builds.

## Test plan
- **Reset:** rst high 2 cycles -> req_ready_o = 1, stall_o = 0, rsp_valid_o = 0, rd_data_o = 0, mem_wr_en_o = 0.
- **L1 read hit:** addr 0x0000_0100, l1_hit_i = 1, mem_rd_data_i = 0xDEAD_BEEF -> rsp_valid_o at T+3, rd_data_o = 0xDEAD_BEEF, stall_o high for exactly 3 cycles.
- **Full miss read**, MEM_LAT = 50 -> rsp_valid_o at T+52, stall_o high for 52 cycles, no mem_wr_en_o.
- **L2 write hit**, byte_en 0011, data 0x0000_ABCD:
  - mem_wr_en_o high only at T+5, with mem_byte_en_o = 0011.
  - rsp_valid_o at T+6.
  - rd_data_o unchanged.
- **Held back-to-back requests** (L1 hits):
  - Second accepted at T+4, and not while busy.
  - Inputs changed during WAIT do not alter mem_addr_o.
- **Reset during the WAIT of an L3 write** -> no mem_wr_en_o pulse, no rsp_valid_o, req_ready_o = 1 the cycle after rst falls.
- **PERF_EN build:** 3 L1 hits then 1 miss -> perf_l1_o = 3, perf_l2_o = 0, perf_l3_o = 0, perf_mem_o = 1.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store sequencer in front of the L1/L2/L3/main-memory hierarchy.
// Optional access counters are built when DATA_MEM_CTRL_PERF_EN is defined.
module data_mem_ctrl #(
    parameter int L1_LAT  = 1,
    parameter int L2_LAT  = 4,
    parameter int L3_LAT  = 10,
    parameter int MEM_LAT = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] addr_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  byte_en_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_data_o,
    output logic [3:0]  mem_byte_en_o,
    input  logic        l1_hit_i,
    input  logic        l2_hit_i,
    input  logic        l3_hit_i,
    input  logic [31:0] mem_rd_data_i,
    output logic        stall_o,
    output logic        rsp_valid_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] perf_l1_o,
    output logic [31:0] perf_l2_o,
    output logic [31:0] perf_l3_o,
    output logic [31:0] perf_mem_o
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wr_data;
    logic [31:0] r_rd_data;
    logic        r_wr_en;
    logic [3:0]  r_byte_en;
    logic [7:0]  r_cnt;
    logic [7:0]  w_lat;
    logic [1:0]  w_lvl;
    logic        w_done;

    // Level index 0..3 = L1, L2, L3, main memory; lowest hitting level wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_lvl = 2'd3;
        if (l1_hit_i)      w_lvl = 2'd0;
        else if (l2_hit_i) w_lvl = 2'd1;
        else if (l3_hit_i) w_lvl = 2'd2;
        case (w_lvl)
            2'd0:    w_lat = 8'(L1_LAT);
            2'd1:    w_lat = 8'(L2_LAT);
            2'd2:    w_lat = 8'(L3_LAT);
            default: w_lat = 8'(MEM_LAT);
        endcase
    end

    assign w_done = (r_state == WAIT) && (r_cnt == 8'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid_i) w_next = LOOKUP;
            LOOKUP:  w_next = WAIT;
            WAIT:    if (w_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_byte_en <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == IDLE && req_valid_i) begin
                r_addr    <= addr_i;
                r_wr_en   <= wr_en_i;
                r_wr_data <= wr_data_i;
                r_byte_en <= byte_en_i;
            end
            if (r_state == LOOKUP)
                r_cnt <= w_lat - 8'd1;
            else if (r_state == WAIT && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
            if (w_done && !r_wr_en)
                r_rd_data <= mem_rd_data_i;
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign stall_o       = (r_state == LOOKUP) || (r_state == WAIT) ||
                           ((r_state == IDLE) && req_valid_i);
    assign rsp_valid_o   = (r_state == RESP);
    // A reset landing on the commit cycle must not leak a write to the hierarchy.
    assign mem_wr_en_o   = w_done && r_wr_en && !rst;
    assign mem_addr_o    = r_addr;
    assign mem_wr_data_o = r_wr_data;
    assign mem_byte_en_o = r_byte_en;
    assign rd_data_o     = r_rd_data;

`ifdef DATA_MEM_CTRL_PERF_EN
    logic [31:0] r_perf [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counter array is small and architecturally visible, so it is reset explicitly.
            for (int i = 0; i < 4; i++) r_perf[i] <= '0;
        end else if (r_state == LOOKUP && r_perf[w_lvl] != 32'hFFFF_FFFF) begin
            r_perf[w_lvl] <= r_perf[w_lvl] + 32'd1;
        end
    end

    assign perf_l1_o  = r_perf[0];
    assign perf_l2_o  = r_perf[1];
    assign perf_l3_o  = r_perf[2];
    assign perf_mem_o = r_perf[3];
`else
    assign perf_l1_o  = '0;
    assign perf_l2_o  = '0;
    assign perf_l3_o  = '0;
    assign perf_mem_o = '0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus randomized accesses
// checked cycle by cycle against a transaction-level timing model.
module tb_data_mem_ctrl;

    localparam int L1_LAT  = 1;
    localparam int L2_LAT  = 4;
    localparam int L3_LAT  = 10;
    localparam int MEM_LAT = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic [3:0]  byte_en_i;
    logic [31:0] mem_addr_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_data_o;
    logic [3:0]  mem_byte_en_o;
    logic        l1_hit_i;
    logic        l2_hit_i;
    logic        l3_hit_i;
    logic [31:0] mem_rd_data_i;
    logic        stall_o;
    logic        rsp_valid_o;
    logic [31:0] rd_data_o;
    logic [31:0] perf_l1_o;
    logic [31:0] perf_l2_o;
    logic [31:0] perf_l3_o;
    logic [31:0] perf_mem_o;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .L1_LAT(L1_LAT), .L2_LAT(L2_LAT), .L3_LAT(L3_LAT), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .addr_i(addr_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .byte_en_i(byte_en_i),
        .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_byte_en_o(mem_byte_en_o),
        .l1_hit_i(l1_hit_i), .l2_hit_i(l2_hit_i), .l3_hit_i(l3_hit_i),
        .mem_rd_data_i(mem_rd_data_i),
        .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rd_data_o(rd_data_o),
        .perf_l1_o(perf_l1_o), .perf_l2_o(perf_l2_o),
        .perf_l3_o(perf_l3_o), .perf_mem_o(perf_mem_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the hierarchy ports and read port should show.
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_be;
    logic [31:0] m_perf [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] perf_exp(input int idx);
`ifdef DATA_MEM_CTRL_PERF_EN
        return m_perf[idx];
`else
        return (idx < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_addr = '0; m_wdata = '0; m_be = '0; m_rd = '0;
        for (int i = 0; i < 4; i++) m_perf[i] = '0;
    endtask

    task automatic drive_noise();
        addr_i        = $urandom;
        wr_en_i       = 1'($urandom);
        wr_data_i     = $urandom;
        byte_en_i     = 4'($urandom);
        {l3_hit_i, l2_hit_i, l1_hit_i} = 3'($urandom);
        mem_rd_data_i = $urandom;
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".addr"},  mem_addr_o, m_addr);
        check({tag, ".wdata"}, mem_wr_data_o, m_wdata);
        check({tag, ".be"},    32'(mem_byte_en_o), 32'(m_be));
        check({tag, ".rd"},    rd_data_o, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_noise();
            req_valid_i = 1'b0;
            #1;
            check("idle.ready", 32'(req_ready_o), 32'd1);
            check("idle.stall", 32'(stall_o), 32'd0);
            check("idle.rsp",   32'(rsp_valid_o), 32'd0);
            check("idle.wr_en", 32'(mem_wr_en_o), 32'd0);
            check_ports("idle");
        end
    endtask

    // One full access: hits = {l3,l2,l1}; hold keeps req_valid_i high while busy.
    task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [2:0] hits,
                          input logic [31:0] rdata, input logic hold);
        int lvl, lat;
        lvl = hits[0] ? 0 : hits[1] ? 1 : hits[2] ? 2 : 3;
        lat = (lvl == 0) ? L1_LAT : (lvl == 1) ? L2_LAT : (lvl == 2) ? L3_LAT : MEM_LAT;

        @(negedge clk);
        drive_noise();
        req_valid_i = 1'b1;
        addr_i = addr; wr_en_i = wr; wr_data_i = wdata; byte_en_i = be;
        #1;
        check("acc.ready0", 32'(req_ready_o), 32'd1);
        check("acc.stall0", 32'(stall_o), 32'd1);
        check("acc.rsp0",   32'(rsp_valid_o), 32'd0);
        check_ports("acc.held");
        m_addr = addr; m_wdata = wdata; m_be = be;

        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            drive_noise();
            req_valid_i = hold ? 1'b1 : 1'($urandom);
            if (k == 1) {l3_hit_i, l2_hit_i, l1_hit_i} = hits;
            if (k == lat + 1) mem_rd_data_i = rdata;
            #1;
            check("acc.stall", 32'(stall_o), 32'(k <= lat + 1));
            check("acc.ready", 32'(req_ready_o), 32'd0);
            check("acc.rsp",   32'(rsp_valid_o), 32'(k == lat + 2));
            check("acc.wr_en", 32'(mem_wr_en_o), 32'(wr && (k == lat + 1)));
            check_ports("acc");
            if (k == 1 && m_perf[lvl] != 32'hFFFF_FFFF) m_perf[lvl] = m_perf[lvl] + 32'd1;
            if (k == lat + 1 && !wr) m_rd = rdata;
            if (k == lat + 2) begin
                check("perf.l1",  perf_l1_o,  perf_exp(0));
                check("perf.l2",  perf_l2_o,  perf_exp(1));
                check("perf.l3",  perf_l3_o,  perf_exp(2));
                check("perf.mem", perf_mem_o, perf_exp(3));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        drive_noise();
        model_reset();

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        #1;
        check("rst.ready", 32'(req_ready_o), 32'd1);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.rsp",   32'(rsp_valid_o), 32'd0);
        check("rst.wr_en", 32'(mem_wr_en_o), 32'd0);
        check_ports("rst");
        rst = 1'b0;
        idle(2);

        // L1 read hit, full miss read, L2 partial write.
        access(32'h0000_0100, 1'b0, 32'h0, 4'hF, 3'b001, 32'hDEAD_BEEF, 1'b0);
        access(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'b000, 32'h1234_5678, 1'b0);
        access(32'h0000_0300, 1'b1, 32'h0000_ABCD, 4'b0011, 3'b010, 32'hFFFF_0000, 1'b0);
        idle(1);

        // Back-to-back L1 hits with the next request held during the first.
        access(32'h0000_0400, 1'b0, 32'h0, 4'hF, 3'b001, 32'hAAAA_0001, 1'b1);
        access(32'h0000_0404, 1'b0, 32'h0, 4'hF, 3'b111, 32'hAAAA_0002, 1'b0);

        // Zero byte-enable write still commits.
        access(32'h0000_0500, 1'b1, 32'h5555_5555, 4'b0000, 3'b100, 32'h0, 1'b0);

        // Randomized accesses.
        for (int i = 0; i < 30; i++) begin
            access($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // Reset wins over an accept in the same cycle.
        @(negedge clk);
        rst = 1'b1; req_valid_i = 1'b1; addr_i = 32'hCAFE_0000;
        @(negedge clk);
        rst = 1'b0; req_valid_i = 1'b0;
        model_reset();
        #1;
        check("rstacc.ready", 32'(req_ready_o), 32'd1);
        check("rstacc.stall", 32'(stall_o), 32'd0);
        check_ports("rstacc");

        // Reset in the WAIT of an L3 write: nothing commits, no response.
        @(negedge clk);
        req_valid_i = 1'b1; addr_i = 32'h0000_0600; wr_en_i = 1'b1;
        wr_data_i = 32'h0BAD_F00D; byte_en_i = 4'hF;
        @(negedge clk);
        req_valid_i = 1'b0; {l3_hit_i, l2_hit_i, l1_hit_i} = 3'b100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait.wr_en", 32'(mem_wr_en_o), 32'd0);
        check("rstwait.stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rstwait.ready", 32'(req_ready_o), 32'd1);
        idle(15);

        // Counter scenario: three L1 hits then one miss.
        for (int i = 0; i < 3; i++)
            access(32'h100 + 32'(i * 4), 1'b0, 32'h0, 4'hF, 3'b001, $urandom, 1'b0);
        access(32'h0000_9000, 1'b0, 32'h0, 4'hF, 3'b000, $urandom, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
